// File: rtl/mac_array_seq_if.sv
// mac_array_seq_if: control, imap read and psum stream signals of the
// 3x3 MAC array sequencer, seen from the controller (master) and sequencer (slave).
interface mac_array_seq_if #(
    parameter int DIM_W     = 6,
    parameter int CH_W      = 8,
    parameter int GRP_W     = 2,
    parameter int OUT_IDX_W = 2 * DIM_W
);
    logic [DIM_W-1:0]                  cfg_w;
    logic [DIM_W-1:0]                  cfg_h;
    logic [GRP_W-1:0]                  cfg_grp;
    logic [CH_W-1:0]                   cfg_och;
    logic                              start;
    logic                              abort;
    logic                              acc_rdy;
    logic                              busy;
    logic                              done;
    logic                              pipe_en;
    logic [9:0]                        pe_en;
    logic [GRP_W:0]                    weight_sel;
    logic                              imap_ren;
    logic [GRP_W+OUT_IDX_W-1:0]        imap_raddr;
    logic                              acc_vld;
    logic [CH_W+GRP_W+OUT_IDX_W-1:0]   acc_info;

    modport master (
        output cfg_w, cfg_h, cfg_grp, cfg_och, start, abort, acc_rdy,
        input  busy, done, pipe_en, pe_en, weight_sel,
        input  imap_ren, imap_raddr, acc_vld, acc_info
    );

    modport slave (
        input  cfg_w, cfg_h, cfg_grp, cfg_och, start, abort, acc_rdy,
        output busy, done, pipe_en, pe_en, weight_sel,
        output imap_ren, imap_raddr, acc_vld, acc_info
    );
endinterface

// File: rtl/mac_array_seq.sv
// mac_array_seq: runtime-configurable sequencer for the 3x3 MAC array.
// Walks pixels, input groups and output channels with 1-pixel zero padding.
module mac_array_seq #(
    parameter int DIM_W     = 6,
    parameter int CH_W      = 8,
    parameter int GRP_W     = 2,
    parameter int PIPE_LAT  = 6,
    parameter int OUT_IDX_W = 2 * DIM_W
) (
    input  logic           clk,
    input  logic           rst,
    mac_array_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, CONV, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [DIM_W-1:0]       w_q, w_d, h_q, h_d;
    logic [GRP_W-1:0]       gmax_q, gmax_d;
    logic [CH_W-1:0]        omax_q, omax_d;
    logic [OUT_IDX_W-1:0]   pmax_q, pmax_d;
    logic [DIM_W:0]         setup_q, setup_d;
    logic [DIM_W-1:0]       col_q, col_d, row_q, row_d;
    logic [GRP_W-1:0]       grp_q, grp_d;
    logic [CH_W-1:0]        och_q, och_d;
    logic [OUT_IDX_W-1:0]   rpix_q, rpix_d;
    logic [OUT_IDX_W-1:0]   opix_q, opix_d;
    logic [GRP_W-1:0]       ogrp_q, ogrp_d;
    logic [CH_W-1:0]        ooch_q, ooch_d;
    logic [PIPE_LAT-1:0]    vld_q, vld_d;
    logic                   done_q, done_d;

    logic                   busy, pipe_en, imap_ren, acc_vld, acc_fire;
    logic                   col_last, row_last, grp_last, och_last;
    logic                   opix_last, ogrp_last, ooch_last;
    logic [8:0]             mask;
    logic [2*DIM_W+1:0]     area;

    assign busy     = (state_q != IDLE);
    assign pipe_en  = busy & bus.acc_rdy;
    assign imap_ren = pipe_en & ((state_q == SETUP) | (state_q == CONV));
    assign acc_vld  = vld_q[PIPE_LAT-1];
    assign acc_fire = acc_vld & bus.acc_rdy;

    assign col_last  = (col_q == w_q);
    assign row_last  = (row_q == h_q);
    assign grp_last  = (grp_q == gmax_q);
    assign och_last  = (och_q == omax_q);
    assign opix_last = (opix_q == pmax_q);
    assign ogrp_last = (ogrp_q == gmax_q);
    assign ooch_last = (ooch_q == omax_q);

    assign area = {{(DIM_W+1){1'b0}}, {1'b0, bus.cfg_h} + (DIM_W+1)'(1)}
                * {{(DIM_W+1){1'b0}}, {1'b0, bus.cfg_w} + (DIM_W+1)'(1)};

    // Bit 3*(2-kr)+(2-kc) is tap (kr,kc); edge rows/cols see padding zeros.
    always_comb begin
        mask = 9'h1FF;
        if (row_q == '0) mask[8:6] = 3'b000;
        if (row_last)    mask[2:0] = 3'b000;
        if (col_q == '0) begin
            mask[8] = 1'b0;
            mask[5] = 1'b0;
            mask[2] = 1'b0;
        end
        if (col_last) begin
            mask[6] = 1'b0;
            mask[3] = 1'b0;
            mask[0] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        gmax_d  = gmax_q;
        omax_d  = omax_q;
        pmax_d  = pmax_q;
        setup_d = setup_q;
        col_d   = col_q;
        row_d   = row_q;
        grp_d   = grp_q;
        och_d   = och_q;
        rpix_d  = rpix_q;
        opix_d  = opix_q;
        ogrp_d  = ogrp_q;
        ooch_d  = ooch_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETUP;
                    w_d     = bus.cfg_w;
                    h_d     = bus.cfg_h;
                    gmax_d  = bus.cfg_grp;
                    omax_d  = bus.cfg_och;
                    pmax_d  = OUT_IDX_W'(area - (2*DIM_W+2)'(1));
                end
            end
            SETUP: begin
                if (pipe_en) begin
                    if (setup_q == {1'b0, w_q} + (DIM_W+1)'(1)) begin
                        setup_d = '0;
                        state_d = CONV;
                    end else begin
                        setup_d = setup_q + (DIM_W+1)'(1);
                    end
                end
            end
            CONV: begin
                if (pipe_en) begin
                    col_d = col_last ? '0 : col_q + DIM_W'(1);
                    if (col_last) begin
                        row_d = row_last ? '0 : row_q + DIM_W'(1);
                        if (row_last) begin
                            grp_d = grp_last ? '0 : grp_q + GRP_W'(1);
                            if (grp_last) begin
                                och_d = och_last ? '0 : och_q + CH_W'(1);
                                if (och_last) state_d = DRAIN;
                            end
                        end
                    end
                end
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase

        if (imap_ren) rpix_d = (rpix_q == pmax_q) ? '0 : rpix_q + OUT_IDX_W'(1);
        if (pipe_en) vld_d = PIPE_LAT'({vld_q, state_q == CONV});

        // Output counters track the beats leaving the array, not the issue side.
        if (acc_fire) begin
            opix_d = opix_last ? '0 : opix_q + OUT_IDX_W'(1);
            if (opix_last) begin
                ogrp_d = ogrp_last ? '0 : ogrp_q + GRP_W'(1);
                if (ogrp_last) ooch_d = ooch_last ? '0 : ooch_q + CH_W'(1);
            end
            if (opix_last && ogrp_last && ooch_last && state_q == DRAIN) begin
                state_d = IDLE;
                done_d  = 1'b1;
                rpix_d  = '0;
            end
        end

        if (bus.abort) begin
            state_d = IDLE;
            setup_d = '0;
            col_d   = '0;
            row_d   = '0;
            grp_d   = '0;
            och_d   = '0;
            rpix_d  = '0;
            opix_d  = '0;
            ogrp_d  = '0;
            ooch_d  = '0;
            vld_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            gmax_q  <= '0;
            omax_q  <= '0;
            pmax_q  <= '0;
            setup_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            grp_q   <= '0;
            och_q   <= '0;
            rpix_q  <= '0;
            opix_q  <= '0;
            ogrp_q  <= '0;
            ooch_q  <= '0;
            vld_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            gmax_q  <= gmax_d;
            omax_q  <= omax_d;
            pmax_q  <= pmax_d;
            setup_q <= setup_d;
            col_q   <= col_d;
            row_q   <= row_d;
            grp_q   <= grp_d;
            och_q   <= och_d;
            rpix_q  <= rpix_d;
            opix_q  <= opix_d;
            ogrp_q  <= ogrp_d;
            ooch_q  <= ooch_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done_q;
    assign bus.pipe_en    = pipe_en;
    assign bus.pe_en      = (state_q == CONV) ? {1'b1, mask} : 10'd0;
    assign bus.weight_sel = {och_q[0], grp_q};
    assign bus.imap_ren   = imap_ren;
    assign bus.imap_raddr = {grp_q, rpix_q};
    assign bus.acc_vld    = acc_vld;
    assign bus.acc_info   = {ooch_q, ogrp_q, opix_q};
endmodule
